// File: rtl/sort_pkg.sv
// Shared types for the 8-lane sorting network and its downstream stages.
//   data_t          : one 32-bit sorted word
//   N_LANES_DEFAULT : words per sorted frame
//   frame_t         : one full frame, lane 0 in the low slot
//   ser_state_t     : serializer FSM states
package sort_pkg;

  typedef logic [31:0] data_t;

  localparam int unsigned N_LANES_DEFAULT = 8;

  typedef data_t [N_LANES_DEFAULT-1:0] frame_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_t;

endpackage

// File: rtl/sort_8_serializer.sv
// sort_8_serializer: captures one sorted 8-word frame from the sorter and
// streams it out one word per cycle, lane 0 first, with a last-word marker.
// Back-to-back frames stream without a bubble.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : frame capture handshake (in_ready is combinational)
//   sort_0..sort_7     : sorted frame, lane 0 = smallest
//   out_valid/ready    : output word handshake
//   out_data/idx/last  : current word, its lane index, last-lane flag
//   err_order          : sticky frame-order error
//
// Optional feature: define SORT_SER_ORDER_CHECK_EN to enable the frame-order
// check driving err_order; otherwise err_order is tied to 0.
module sort_8_serializer
  import sort_pkg::*;
#(
  parameter int unsigned N_LANES = N_LANES_DEFAULT,
  parameter int unsigned IDX_W   = $clog2(N_LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  data_t            sort_0,
  input  data_t            sort_1,
  input  data_t            sort_2,
  input  data_t            sort_3,
  input  data_t            sort_4,
  input  data_t            sort_5,
  input  data_t            sort_6,
  input  data_t            sort_7,
  output logic             out_valid,
  input  logic             out_ready,
  output data_t            out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             err_order
);

  ser_state_t       state_q, state_d;
  frame_t           frame_q, frame_d;
  frame_t           in_frame;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_valid_d, out_last_d;
  data_t            out_data_d;
  logic [IDX_W-1:0] out_idx_d;
  logic             capture, accept;

  assign in_frame = {sort_7, sort_6, sort_5, sort_4, sort_3, sort_2, sort_1, sort_0};

  // Ready when idle, or when the last word leaves this cycle.
  assign in_ready = !rst && ((state_q == IDLE) || (out_valid && out_ready && out_last));
  assign capture  = in_valid && in_ready;
  assign accept   = out_valid && out_ready;

  // Next state, frame, index, and the registered output image of the next word.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    if (capture) begin
      state_d = STREAM;
      frame_d = in_frame;
      idx_d   = '0;
    end else if (accept) begin
      if (out_last) state_d = IDLE;
      else          idx_d   = idx_q + IDX_W'(1);
    end
    out_valid_d = (state_d == STREAM);
    out_data_d  = out_valid_d ? frame_d[idx_d] : '0;
    out_idx_d   = out_valid_d ? idx_d : '0;
    out_last_d  = out_valid_d && (idx_d == IDX_W'(N_LANES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_idx   <= out_idx_d;
      out_last  <= out_last_d;
    end
  end

`ifdef SORT_SER_ORDER_CHECK_EN
  logic order_viol;
  logic err_q;

  // Unsigned non-decreasing check across adjacent lanes; equal is legal.
  always_comb begin
    order_viol = 1'b0;
    for (int i = 0; i < int'(N_LANES_DEFAULT) - 1; i++) begin
      if (in_frame[i] > in_frame[i+1]) order_viol = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          err_q <= 1'b0;
    else if (capture && order_viol)   err_q <= 1'b1;
  end

  assign err_order = err_q;
`else
  assign err_order = 1'b0;
`endif

endmodule

// File: tb/tb_sort_8_serializer.sv
// Self-checking bench for sort_8_serializer. A queue of pending words models
// the stream: the head is what must be on the output, a capture appends eight.
module tb_sort_8_serializer;
  import sort_pkg::*;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, out_last, err_order;
  data_t      sv [8];
  data_t      out_data;
  logic [2:0] out_idx;

  sort_8_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sort_0(sv[0]), .sort_1(sv[1]), .sort_2(sv[2]), .sort_3(sv[3]),
    .sort_4(sv[4]), .sort_5(sv[5]), .sort_6(sv[6]), .sort_7(sv[7]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .err_order(err_order)
  );

  always #5 clk = ~clk;

  typedef struct {
    data_t      d;
    logic [2:0] i;
    logic       l;
  } word_t;

  word_t q[$];
  logic  err_m;
  data_t cur [8];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  obs_rdy, obs_acc;

  // One clock cycle: drive, compare against the model, clock, update model.
  task automatic step(input logic r, input logic iv, input logic ordy);
    logic  exp_rdy, exp_v, exp_l, cap, acc, viol;
    data_t exp_d;
    logic [2:0] exp_i;
    word_t w;
    rst = r; in_valid = iv; out_ready = ordy;
    for (int k = 0; k < 8; k++) sv[k] = cur[k];
    #1;
    exp_rdy = !r && (q.size() == 0 || (q.size() == 1 && ordy));
    exp_v   = (q.size() != 0);
    exp_d   = exp_v ? q[0].d : '0;
    exp_i   = exp_v ? q[0].i : '0;
    exp_l   = exp_v ? q[0].l : 1'b0;
    n_tests += 6;
    if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL in_ready got %b want %b t=%0t", in_ready, exp_rdy, $time); end
    if (out_valid !== exp_v)  begin n_fail++; $display("FAIL out_valid got %b want %b t=%0t", out_valid, exp_v, $time); end
    if (out_data !== exp_d)   begin n_fail++; $display("FAIL out_data got %0d want %0d t=%0t", out_data, exp_d, $time); end
    if (out_idx !== exp_i)    begin n_fail++; $display("FAIL out_idx got %0d want %0d t=%0t", out_idx, exp_i, $time); end
    if (out_last !== exp_l)   begin n_fail++; $display("FAIL out_last got %b want %b t=%0t", out_last, exp_l, $time); end
    if (err_order !== err_m)  begin n_fail++; $display("FAIL err_order got %b want %b t=%0t", err_order, err_m, $time); end
    obs_rdy = in_ready;
    obs_acc = out_valid && out_ready;
    acc = exp_v && ordy;
    cap = iv && exp_rdy;
    viol = 1'b0;
    for (int k = 0; k < 7; k++) if (cur[k] > cur[k+1]) viol = 1'b1;
    @(posedge clk);
    if (r) begin
      q.delete();
      err_m = 1'b0;
    end else begin
      if (acc) void'(q.pop_front());
      if (cap) begin
        for (int k = 0; k < 8; k++) begin
          w.d = cur[k]; w.i = 3'(k); w.l = (k == 7);
          q.push_back(w);
        end
`ifdef SORT_SER_ORDER_CHECK_EN
        if (viol) err_m = 1'b1;
`endif
      end
    end
    #1;
  endtask

  task automatic set_seq(input int base);
    for (int k = 0; k < 8; k++) cur[k] = data_t'(base + k);
  endtask

  task automatic set_rand_sorted();
    for (int k = 0; k < 8; k++) cur[k] = $urandom;
    cur.sort();
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    set_seq(1);
    step(1'b0, 1'b1, 1'b1);
    set_rand_sorted();
    for (int c = 0; c < 9; c++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int acc_n = 0, rdy_n = 0;
    set_seq(1);
    step(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 1'b1, logic'(c % 2));
      if (obs_acc) acc_n++;
      if (obs_rdy) rdy_n++;
      if (c == 15) in_valid = 1'b0;
    end
    n_tests += 2;
    if (acc_n != 8) begin n_fail++; $display("FAIL bp_accepts got %0d want 8", acc_n); end
    if (rdy_n != 1) begin n_fail++; $display("FAIL bp_in_ready_cycles got %0d want 1", rdy_n); end
    // The accept at c=15 also captured a frame; drain it.
    for (int c = 0; c < 9; c++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int acc_n = 0, rdy_n = 0;
    set_seq(1);
    step(1'b0, 1'b1, 1'b1);
    if (obs_rdy) rdy_n++;
    set_seq(11);
    for (int c = 1; c <= 16; c++) begin
      step(1'b0, logic'(c <= 8), 1'b1);
      if (obs_acc) acc_n++;
      if (obs_rdy) rdy_n++;
    end
    n_tests += 2;
    if (acc_n != 16) begin n_fail++; $display("FAIL b2b_accepts got %0d want 16", acc_n); end
    if (rdy_n != 3)  begin n_fail++; $display("FAIL b2b_in_ready_cycles got %0d want 3", rdy_n); end
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    set_rand_sorted();
    step(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    set_seq(21);
    step(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 9; c++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_order();
    cur = '{32'd5, 32'd3, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11};
    step(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b1);
    set_seq(1);
    step(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) cur[k] = 32'd4;
    step(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 9; c++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(7) == 0) begin
        for (int k = 0; k < 8; k++) cur[k] = $urandom;
      end else begin
        set_rand_sorted();
      end
      step(logic'($urandom_range(59) == 0), logic'($urandom_range(1)),
           logic'($urandom_range(3) != 0));
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin cur[k] = '0; sv[k] = '0; end
    err_m = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_order();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
